// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
//   Issues sequential word reads from fetch_pc, keeps up to DEPTH requests
//   in flight, and queues returned words as {pc, data} for the core. A
//   redirect flushes the queue and discards every response still in flight.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   redirect_valid, redirect_pc     one-cycle restart request and target
//   mem_req_valid/ready/addr        instruction read request channel
//   mem_rsp_valid/data              in-order read responses (one-cycle pulses)
//   inst_valid/ready/data/pc        instruction stream to the core
//   inst_fault                      only with FETCH_MISALIGN_CHECK_EN defined
//
// Build option FETCH_MISALIGN_CHECK_EN: a misaligned redirect target issues
// no fetch and presents a single faulting NOP entry, then stalls until the
// next redirect. Without it, redirect_pc[1:0] is ignored.

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        inst_fault
`endif
);

    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [31:0]      fetch_pc;
    logic [31:0]      rsp_pc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             stall;

    logic [31:0] pc_q   [DEPTH];
    logic [31:0] data_q [DEPTH];
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fault_q [DEPTH];
`endif

    logic [31:0]    redirect_target;
    logic           misaligned;
    logic           req_fire;
    logic           rsp_fire;
    logic           drop;
    logic           push;
    logic           pop;
    logic [CNT_W:0] credit_used;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redirect_target = redirect_pc;
    assign misaligned      = |redirect_pc[1:0];
`else
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign misaligned      = 1'b0;
`endif

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop      = inst_valid & inst_ready;
    assign rsp_fire = mem_rsp_valid & (outstanding != '0);
    assign drop     = rsp_fire & (drop_cnt != '0);
    assign push     = rsp_fire & ~drop & ~redirect_valid;
    assign req_fire = mem_req_valid & mem_req_ready;

    // Slots in use = queued entries + in-flight reads. The entry leaving the
    // queue this cycle frees its slot immediately: a new request cannot land
    // before the next edge, so the queue still cannot overflow, and this is
    // what lets a 1-cycle memory sustain one instruction per cycle.
    assign credit_used = ({1'b0, count} - {{CNT_W{1'b0}}, pop}) + {1'b0, outstanding};

    assign mem_req_valid = ~rst & ~redirect_valid & ~stall & (credit_used < DEPTH_W);
    assign mem_req_addr  = fetch_pc;
    assign inst_valid    = (count != '0);
    assign inst_data     = data_q[head];
    assign inst_pc       = pc_q[head];
`ifdef FETCH_MISALIGN_CHECK_EN
    assign inst_fault    = inst_valid & fault_q[head];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            stall       <= 1'b0;
        end else if (redirect_valid) begin
            // Everything still in flight belongs to the old stream; the
            // response arriving now (if any) is discarded on this edge.
            fetch_pc    <= redirect_target;
            rsp_pc      <= redirect_target;
            head        <= '0;
            outstanding <= outstanding - CNT_W'(rsp_fire);
            drop_cnt    <= outstanding - CNT_W'(rsp_fire);
            stall       <= misaligned;
            if (misaligned) begin
                tail  <= PTR_W'(1);
                count <= CNT_W'(1);
            end else begin
                tail  <= '0;
                count <= '0;
            end
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_fire);
            if (drop) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
            // Responses are in order and requests sequential, so the pc of
            // the next kept response simply follows the last redirect target.
            if (push) begin
                tail   <= ptr_next(tail);
                rsp_pc <= rsp_pc + 32'd4;
            end
            if (pop) begin
                head <= ptr_next(head);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Queue storage needs no reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (redirect_valid) begin
            if (misaligned) begin
                pc_q[0]    <= redirect_target;
                data_q[0]  <= 32'h0000_0013;
`ifdef FETCH_MISALIGN_CHECK_EN
                fault_q[0] <= 1'b1;
`endif
            end
        end else if (push) begin
            pc_q[tail]    <= rsp_pc;
            data_q[tail]  <= mem_rsp_data;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_q[tail] <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a table of per-cycle expectations after reset,
// hand-written redirect/reset corner cases, and a randomized phase. A
// behavioural memory (in-order queue with per-request latency) answers reads
// with a fixed function of the address, and a stream reference checks every
// consumed instruction against the next expected program-order pc.

module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          DEPTH    = 2;

    logic        clk            = 1'b0;
    logic        rst            = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        mem_req_valid;
    logic        mem_req_ready  = 1'b1;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid  = 1'b0;
    logic [31:0] mem_rsp_data   = '0;
    logic        inst_valid;
    logic        inst_ready     = 1'b1;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        inst_fault;
`endif

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .inst_fault     (inst_fault)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic        rdy;
        logic [31:0] exp_mrv;
        logic [31:0] exp_addr;
        logic [31:0] exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    mreq_t memq[$];
    int    last_due;
    int    lat_min = 1;
    int    lat_max = 1;
    int    cyc     = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_consumed;
    int n_acc;
    int n_rsp;

    logic [31:0] exp_pc;
    logic [31:0] exp_req_addr;

    logic [31:0] s_mrv, s_addr, s_iv, s_pc, s_data, s_rsp, s_fault;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock period: present memory response, sample, update the
    // reference, then advance to the next falling edge.
    task automatic cycle();
        logic [31:0] tgt;
        int          d;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = memfn(memq[0].addr);
            memq.delete(0);
            n_rsp++;
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = $urandom;
        end
        #1;
        s_mrv   = 32'(mem_req_valid);
        s_addr  = mem_req_addr;
        s_iv    = 32'(inst_valid);
        s_pc    = inst_pc;
        s_data  = inst_data;
        s_rsp   = 32'(mem_rsp_valid);
`ifdef FETCH_MISALIGN_CHECK_EN
        s_fault = 32'(inst_fault);
`else
        s_fault = 32'd0;
`endif
        if (rst) begin
            check("rst_mem_req_valid", s_mrv, 32'd0);
            check("rst_inst_valid", s_iv, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
            check("rst_inst_fault", s_fault, 32'd0);
`endif
        end else begin
            if (redirect_valid) check("redirect_no_req", s_mrv, 32'd0);
            if (mem_req_valid && mem_req_ready) begin
                check("req_addr", s_addr, exp_req_addr);
                exp_req_addr = exp_req_addr + 32'd4;
                d = cyc + int'($urandom_range(lat_max, lat_min));
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                memq.push_back('{addr: mem_req_addr, due: d});
                n_acc++;
            end
            if (inst_valid && inst_ready) begin
                check("inst_pc", s_pc, exp_pc);
`ifdef FETCH_MISALIGN_CHECK_EN
                if (exp_pc[1:0] != 2'b00) begin
                    check("fault_data", s_data, 32'h0000_0013);
                    check("fault_flag", s_fault, 32'd1);
                end else begin
                    check("inst_data", s_data, memfn(exp_pc));
                    check("fault_flag", s_fault, 32'd0);
                end
`else
                check("inst_data", s_data, memfn(exp_pc));
`endif
                exp_pc = exp_pc + 32'd4;
                n_consumed++;
            end
            if (redirect_valid) begin
                tgt = redirect_pc;
`ifndef FETCH_MISALIGN_CHECK_EN
                tgt[1:0] = 2'b00;
`endif
                exp_pc       = tgt;
                exp_req_addr = tgt;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) cycle();
        rst           = 1'b0;
        memq.delete();
        last_due      = 0;
        exp_pc        = RESET_PC;
        exp_req_addr  = RESET_PC;
        n_consumed    = 0;
        n_acc         = 0;
        n_rsp         = 0;
        mem_req_ready = 1'b1;
        inst_ready    = 1'b1;
    endtask

    // Run until an instruction is consumed; s_pc then holds its pc.
    task automatic wait_inst(input string name, input int bound);
        logic found;
        found = 1'b0;
        for (int k = 0; k < bound; k++) begin
            cycle();
            if (s_iv == 32'd1 && inst_ready) begin
                found = 1'b1;
                break;
            end
        end
        check(name, 32'(found), 32'd1);
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        cycle();
    endtask

    vec_t tbl[11];

    initial begin
        logic [31:0] tgt;
        int          base;

        // Steady stream from reset with a 1-cycle memory, then a 2-cycle
        // consumer stall: first instruction two cycles after reset, then one
        // per cycle; the queue fills to DEPTH and request issue stops.
        tbl[0]  = '{1'b1, 32'd1, RESET_PC + 32'h00, 32'd0, 32'h0};
        tbl[1]  = '{1'b1, 32'd1, RESET_PC + 32'h04, 32'd0, 32'h0};
        tbl[2]  = '{1'b1, 32'd1, RESET_PC + 32'h08, 32'd1, RESET_PC + 32'h00};
        tbl[3]  = '{1'b1, 32'd1, RESET_PC + 32'h0C, 32'd1, RESET_PC + 32'h04};
        tbl[4]  = '{1'b1, 32'd1, RESET_PC + 32'h10, 32'd1, RESET_PC + 32'h08};
        tbl[5]  = '{1'b1, 32'd1, RESET_PC + 32'h14, 32'd1, RESET_PC + 32'h0C};
        tbl[6]  = '{1'b0, 32'd0, 32'h0,             32'd1, RESET_PC + 32'h10};
        tbl[7]  = '{1'b0, 32'd0, 32'h0,             32'd1, RESET_PC + 32'h10};
        tbl[8]  = '{1'b1, 32'd1, RESET_PC + 32'h18, 32'd1, RESET_PC + 32'h10};
        tbl[9]  = '{1'b1, 32'd1, RESET_PC + 32'h1C, 32'd1, RESET_PC + 32'h14};
        tbl[10] = '{1'b1, 32'd1, RESET_PC + 32'h20, 32'd1, RESET_PC + 32'h18};

        do_reset(3);
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 11; i++) begin
            inst_ready = tbl[i].rdy;
            cycle();
            check($sformatf("tbl%0d_mem_req_valid", i), s_mrv, tbl[i].exp_mrv);
            if (tbl[i].exp_mrv == 32'd1) check($sformatf("tbl%0d_mem_req_addr", i), s_addr, tbl[i].exp_addr);
            check($sformatf("tbl%0d_inst_valid", i), s_iv, tbl[i].exp_iv);
            if (tbl[i].exp_iv == 32'd1) check($sformatf("tbl%0d_inst_pc", i), s_pc, tbl[i].exp_pc);
        end

        // Consumer stalled for 10 cycles: queue full, no requests; then
        // DEPTH in-order pops.
        do_reset(2);
        inst_ready = 1'b0;
        repeat (10) cycle();
        check("stall_inst_valid", s_iv, 32'd1);
        check("stall_mem_req_valid", s_mrv, 32'd0);
        check("stall_accepted", 32'(n_acc), 32'(DEPTH));
        check("stall_responses", 32'(n_rsp), 32'(DEPTH));
        inst_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            cycle();
            check("release_inst_valid", s_iv, 32'd1);
            check("release_inst_pc", s_pc, RESET_PC + 32'(4 * i));
        end

        // 3-cycle memory, two reads in flight, redirect: both dropped.
        do_reset(2);
        lat_min = 3; lat_max = 3;
        cycle();
        cycle();
        check("two_outstanding", 32'(n_acc), 32'd2);
        do_redirect(32'h8000_0100);
        wait_inst("redir_inst_seen", 20);
        check("redir_first_pc", s_pc, 32'h8000_0100);
        check("redir_stale_delivered", 32'(n_rsp >= 2), 32'd1);

        // Redirect coinciding with a response and an inst handshake.
        do_reset(2);
        lat_min = 1; lat_max = 1;
        repeat (3) cycle();
        base = n_consumed;
        do_redirect(32'h8000_0200);
        check("coinc_handshake", s_iv, 32'd1);
        check("coinc_response", s_rsp, 32'd1);
        check("coinc_consumed", 32'(n_consumed - base), 32'd1);
        cycle();
        check("coinc_queue_empty", s_iv, 32'd0);
        check("coinc_req_valid", s_mrv, 32'd1);
        check("coinc_req_addr", s_addr, 32'h8000_0200);
        wait_inst("coinc_inst_seen", 10);
        check("coinc_first_pc", s_pc, 32'h8000_0200);

        // Reset pulse mid-stream with reads pending.
        do_reset(2);
        lat_min = 3; lat_max = 3;
        repeat (6) cycle();
        check("rst_pending", 32'(memq.size() > 0), 32'd1);
        do_reset(4);
        lat_min = 3; lat_max = 3;
        cycle();
        check("post_rst_req_valid", s_mrv, 32'd1);
        check("post_rst_req_addr", s_addr, RESET_PC);
        wait_inst("post_rst_inst_seen", 20);
        check("post_rst_first_pc", s_pc, RESET_PC);

        // Address wrap past the top of memory.
        do_reset(2);
        lat_min = 1; lat_max = 1;
        do_redirect(32'hFFFF_FFF8);
        base = n_consumed;
        for (int k = 0; k < 30 && n_consumed - base < 4; k++) cycle();
        check("wrap_consumed", 32'(n_consumed - base), 32'd4);
        check("wrap_next_pc", exp_pc, 32'h0000_0008);

`ifdef FETCH_MISALIGN_CHECK_EN
        // Misaligned target: one faulting NOP, no fetch, stall until redirect.
        do_reset(2);
        repeat (4) cycle();
        inst_ready = 1'b0;
        do_redirect(32'h8000_0102);
        cycle();
        check("mis_inst_valid", s_iv, 32'd1);
        check("mis_fault", s_fault, 32'd1);
        check("mis_pc", s_pc, 32'h8000_0102);
        check("mis_data", s_data, 32'h0000_0013);
        check("mis_no_req", s_mrv, 32'd0);
        repeat (5) begin
            cycle();
            check("mis_stall_no_req", s_mrv, 32'd0);
        end
        inst_ready = 1'b1;
        cycle();
        repeat (3) begin
            cycle();
            check("mis_after_pop_empty", s_iv, 32'd0);
            check("mis_after_pop_no_req", s_mrv, 32'd0);
        end
        do_redirect(32'h8000_0000);
        wait_inst("mis_resume_seen", 10);
        check("mis_resume_pc", s_pc, 32'h8000_0000);
`else
        // Without the check, the low target bits are ignored.
        do_reset(2);
        do_redirect(32'h8000_0102);
        wait_inst("align_inst_seen", 10);
        check("align_forced_pc", s_pc, 32'h8000_0100);
`endif

        // Randomized traffic against the stream reference.
        do_reset(2);
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 800; i++) begin
            mem_req_ready = ($urandom_range(3, 0) != 0);
            inst_ready    = ($urandom_range(3, 0) != 0);
            if ($urandom_range(29, 0) == 0) begin
                case ($urandom_range(2, 0))
                    0:       tgt = RESET_PC + (32'($urandom_range(255, 0)) << 2);
                    1:       tgt = 32'hFFFF_FFF0 + (32'($urandom_range(3, 0)) << 2);
                    default: tgt = $urandom;
                endcase
`ifdef FETCH_MISALIGN_CHECK_EN
                tgt[1:0] = 2'b00;
`endif
                redirect_valid = 1'b1;
                redirect_pc    = tgt;
            end
            cycle();
        end
        check("random_progress", 32'(n_consumed > 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
